// File: rtl/ins_enc_rv32i_s.sv
// Streaming RV32I S-type (SB/SH/SW) encoder with a 2-entry address-tagged output buffer.
// Illegal funct3 inputs are consumed and dropped, flagged by err_pulse/err_sticky.
module ins_enc_rv32i_s #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ins,
  output logic [31:0] addr,
  output logic        err_pulse,
  output logic        err_sticky,
  output logic [15:0] count
);

  logic [31:0] r_headIns;
  logic [31:0] r_headAddr;
  logic [31:0] r_tailIns;
  logic [31:0] r_tailAddr;
  logic [31:0] r_addrCtr;
  logic [1:0]  r_occ;
  logic        r_inReady;
  logic        r_errPulse;
  logic        r_errSticky;
  logic [15:0] r_count;

  logic        w_accept;
  logic        w_legal;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_occNext;
  logic [31:0] w_ins;

  assign w_ins    = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
  assign w_accept = in_valid & r_inReady & ~flush;
  assign w_legal  = (funct3 <= 3'b010);
  assign w_push   = w_accept & w_legal;
  assign w_pop    = (r_occ != 2'd0) & out_ready & ~flush;

  always_comb begin
    w_occNext = r_occ;
    if (w_push && !w_pop)
      w_occNext = r_occ + 2'd1;
    else if (!w_push && w_pop)
      w_occNext = r_occ - 2'd1;
  end

  // Head/tail shift buffer: a push lands in the head when the head is free or being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_headIns   <= 32'd0;
      r_headAddr  <= BASE_ADDR;
      r_tailIns   <= 32'd0;
      r_tailAddr  <= BASE_ADDR;
      r_addrCtr   <= BASE_ADDR;
      r_occ       <= 2'd0;
      r_inReady   <= 1'b0;
      r_errPulse  <= 1'b0;
      r_errSticky <= 1'b0;
      r_count     <= 16'd0;
    end else if (flush) begin
      r_occ       <= 2'd0;
      r_addrCtr   <= BASE_ADDR;
      r_count     <= 16'd0;
      r_errPulse  <= 1'b0;
      r_errSticky <= 1'b0;
      r_inReady   <= 1'b1;
    end else begin
      r_occ      <= w_occNext;
      r_inReady  <= (w_occNext < 2'd2);
      r_errPulse <= w_accept & ~w_legal;
      if (w_accept && !w_legal)
        r_errSticky <= 1'b1;
      if (w_push) begin
        r_addrCtr <= r_addrCtr + 32'd4;
        r_count   <= r_count + 16'd1;
      end
      if (w_push && (r_occ == 2'd0 || (r_occ == 2'd1 && w_pop))) begin
        r_headIns  <= w_ins;
        r_headAddr <= r_addrCtr;
      end else if (w_pop && r_occ == 2'd2) begin
        r_headIns  <= r_tailIns;
        r_headAddr <= r_tailAddr;
      end
      if (w_push && r_occ == 2'd1 && !w_pop) begin
        r_tailIns  <= w_ins;
        r_tailAddr <= r_addrCtr;
      end
    end
  end

  assign in_ready   = r_inReady;
  assign out_valid  = (r_occ != 2'd0);
  assign ins        = r_headIns;
  assign addr       = r_headAddr;
  assign err_pulse  = r_errPulse;
  assign err_sticky = r_errSticky;
  assign count      = r_count;

endmodule

// File: tb/tb_ins_enc_rv32i_s.sv
// Bench for ins_enc_rv32i_s: scoreboard queue of expected {ins, addr} plus per-cycle status model.
// A second instance with BASE_ADDR = 0xFFFF_FFFC shares all inputs to exercise address wrap.
module tb_ins_enc_rv32i_s;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] BASEW = 32'hFFFF_FFFC;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ins;
  logic [31:0] addr;
  logic        err_pulse;
  logic        err_sticky;
  logic [15:0] count;

  logic        wInReady;
  logic        wOutValid;
  logic [31:0] wIns;
  logic [31:0] wAddr;
  logic        wErrPulse;
  logic        wErrSticky;
  logic [15:0] wCount;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] addr;
    logic [31:0] addrW;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] expAddr;
  logic [31:0] expAddrW;
  logic [15:0] expCount;
  logic        expErr;
  logic        expSticky;
  logic        expReady;
  int          checks;
  int          passes;

  ins_enc_rv32i_s #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .ins(ins), .addr(addr), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .count(count)
  );

  ins_enc_rv32i_s #(.BASE_ADDR(BASEW)) dutWrap (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(wInReady),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(wOutValid),
    .out_ready(out_ready), .ins(wIns), .addr(wAddr), .err_pulse(wErrPulse),
    .err_sticky(wErrSticky), .count(wCount)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] encodeStore(input logic [2:0] f3, input logic [4:0] a,
                                              input logic [4:0] b, input logic [11:0] im);
    logic [31:0] w;
    w        = 32'd0;
    w[6:0]   = 7'h23;
    w[11:7]  = im[4:0];
    w[14:12] = f3;
    w[19:15] = a;
    w[24:20] = b;
    w[31:25] = im[11:5];
    return w;
  endfunction

  // One comparison: counts it, and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one cycle of inputs, checks outputs at the falling edge, then advances the model.
  task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [4:0] a,
                               input logic [4:0] b, input logic [11:0] im,
                               input logic ordy, input logic fl);
    exp_t e;
    logic acc;
    in_valid  = v;
    funct3    = f3;
    rs1       = a;
    rs2       = b;
    imm       = im;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, sbq.size() != 0});
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
    checkOutput("count", {16'd0, count}, {16'd0, expCount});
    checkOutput("err_pulse", {31'd0, err_pulse}, {31'd0, expErr});
    checkOutput("err_sticky", {31'd0, err_sticky}, {31'd0, expSticky});
    if (sbq.size() != 0) begin
      e = sbq[0];
      checkOutput("ins", ins, e.ins);
      checkOutput("addr", addr, e.addr);
      checkOutput("addr_wrap", wAddr, e.addrW);
      if (ordy && !fl)
        e = sbq.pop_front();
    end
    acc    = v && expReady && !fl;
    expErr = acc && (f3 > 3'b010);
    if (fl) begin
      sbq.delete();
      expAddr   = BASE;
      expAddrW  = BASEW;
      expCount  = 16'd0;
      expSticky = 1'b0;
    end else if (acc && f3 <= 3'b010) begin
      e.ins   = encodeStore(f3, a, b, im);
      e.addr  = expAddr;
      e.addrW = expAddrW;
      sbq.push_back(e);
      expAddr  = expAddr + 32'd4;
      expAddrW = expAddrW + 32'd4;
      expCount = expCount + 16'd1;
    end else if (acc) begin
      expSticky = 1'b1;
    end
    expReady = fl ? 1'b1 : (sbq.size() < 2);
    @(posedge clk);
    #1;
  endtask

  // Asserts rst_n between edges, checks reset values immediately, then releases it.
  task automatic doReset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst_n    = 1'b0;
    #2;
    sbq.delete();
    expAddr   = BASE;
    expAddrW  = BASEW;
    expCount  = 16'd0;
    expErr    = 1'b0;
    expSticky = 1'b0;
    expReady  = 1'b0;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_ins", ins, 32'd0);
    checkOutput("rst_addr", addr, BASE);
    checkOutput("rst_addr_wrap", wAddr, BASEW);
    checkOutput("rst_count", {16'd0, count}, 32'd0);
    checkOutput("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    checkOutput("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    expReady = 1'b1;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    funct3    = 3'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    imm       = 12'd0;
    out_ready = 1'b1;
    #1;
    doReset();
    $display("[TB] reset released");

    // Single SW, then a negative-offset SB right behind it.
    applyStimulus(1'b1, 3'b010, 5'd2, 5'd5, 12'd8, 1'b1, 1'b0);
    checkOutput("sw_ins", ins, 32'h0051_2423);
    checkOutput("sw_addr", addr, 32'h0000_0000);
    checkOutput("sw_count", {16'd0, count}, 32'd1);
    applyStimulus(1'b1, 3'b000, 5'd3, 5'd1, 12'hFFF, 1'b1, 1'b0);
    checkOutput("sb_ins", ins, 32'hFE11_8FA3);
    checkOutput("sb_addr", addr, 32'h0000_0004);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);

    // Backpressure: three words offered against a stalled sink.
    $display("[TB] backpressure");
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'b010, 5'd1, 5'd2, 12'h010, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b001, 5'd3, 5'd4, 12'h7FF, 1'b0, 1'b0);
    checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b1, 3'b000, 5'd5, 5'd6, 12'h800, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 5'd5, 5'd6, 12'h800, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b000, 5'd5, 5'd6, 12'h800, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b000, 5'd5, 5'd6, 12'h800, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);

    // Illegal funct3 sandwiched between two legal words.
    $display("[TB] illegal funct3");
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'b010, 5'd7, 5'd8, 12'h004, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b011, 5'd9, 5'd10, 12'h0AA, 1'b1, 1'b0);
    checkOutput("err_pulse_high", {31'd0, err_pulse}, 32'd1);
    applyStimulus(1'b1, 3'b001, 5'd11, 5'd12, 12'h123, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'b111, 5'd1, 5'd1, 12'h001, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);
    checkOutput("illegal_count", {16'd0, count}, 32'd2);
    checkOutput("illegal_sticky", {31'd0, err_sticky}, 32'd1);

    // Flush with two words buffered and a word offered in the flush cycle.
    $display("[TB] flush");
    applyStimulus(1'b1, 3'b010, 5'd13, 5'd14, 12'h020, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b010, 5'd15, 5'd16, 12'h024, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b010, 5'd17, 5'd18, 12'h028, 1'b1, 1'b1);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_count", {16'd0, count}, 32'd0);
    checkOutput("flush_sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 3'b001, 5'd19, 5'd20, 12'h02C, 1'b1, 1'b0);
    checkOutput("post_flush_addr", addr, BASE);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, then resume; the wrap instance crosses 2^32.
    $display("[TB] async reset mid-stream");
    applyStimulus(1'b1, 3'b010, 5'd21, 5'd22, 12'h030, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'b010, 5'd23, 5'd24, 12'h034, 1'b0, 1'b0);
    doReset();
    applyStimulus(1'b1, 3'b010, 5'd25, 5'd26, 12'h038, 1'b1, 1'b0);
    checkOutput("resume_addr", addr, BASE);
    checkOutput("wrap_first_addr", wAddr, BASEW);
    applyStimulus(1'b1, 3'b000, 5'd27, 5'd28, 12'hF00, 1'b1, 1'b0);
    checkOutput("wrap_second_addr", wAddr, 32'h0000_0000);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 12'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
